alu_slice_serial: RTL
=====================

# alu_slice_serial

Parametrised multi-cycle ALU that evaluates a WIDTH-bit operation one SLICE-bit slice per clock, LSB slice first, carrying between slices in a register instead of a combinational ripple chain. It uses the team's 16-code M/S function set and accepts one operation per start/done handshake. It is the sequenced, width-generic successor to the fixed 16-bit ripple ALU in the datapath. It trades latency for a short critical path of one slice.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of SLICE
- SLICE, 4, bits evaluated per cycle; N = WIDTH/SLICE cycles per operation
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled on rising edges
- a, b  in  WIDTH  operands
- m  in  1  mode: 0 = arithmetic, 1 = logic
- s  in  4  function select, same coding as the existing slice ALU
- cin  in  1  carry-in, active-high (+1)
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse: f, cout and zero are valid
- f  out  WIDTH  result, held from done until the next done
- cout  out  1  carry out of the MSB slice; 0 in logic mode
- zero  out  1  high when f == 0; updated with f

## Operation
- Only one clock (clk) and one reset (rst). rst is asynchronous and active-high. While rst is high, busy, done, f, cout and zero are 0, the slice index is 0 and the carry register is 0.
- States:
  - IDLE (busy=0)
  - RUN (busy=1, slice index i = 0..N-1)
- IDLE -> RUN on an edge with start=1:
  - latch a, b, m, s into internal registers
  - carry register <= cin (forced to 0 if m=1)
  - i <= 0
  - partial-result register cleared
- RUN, each edge:
  - slice i is computed from the latched a/b bits [i*SLICE +: SLICE], the latched m/s and the carry register
  - the slice result is written to partial[i*SLICE +: SLICE]
  - carry register <= slice carry-out
  - i <= i+1
- Completion, on the edge where i == N-1:
  - f <= full partial result, including this slice
  - cout <= final carry (0 if m=1)
  - zero <= (full result == 0)
  - done <= 1, busy <= 0, return to IDLE
- Arithmetic (m=0) is computed modulo 2^WIDTH. Subtract code (s=0110) gives A - B - 1 + cin; cout=1 means no borrow. Logic mode (m=1) is bitwise, with no inter-slice carry.
- start while busy=1 is ignored. The latched operands and controls are not disturbed.
- Changes on a, b, m, s or cin after the accepting edge have no effect on the running operation.
- f, cout and zero change only on a completion edge or on reset.
- rst asserted mid-operation aborts it: no done is produced and all outputs go to their reset values.

## Timing
- Start accepted at edge k. done is high in the cycle after edge k+N (N=4 for the defaults). Latency is N cycles.
- done is high for exactly one cycle. busy is high from after edge k through the cycle before done.
- start=1 in the done cycle is accepted at the next edge, since busy=0. Maximum throughput is one operation per N+1 cycles.
- SLICE == WIDTH is legal: N=1, done one cycle after start.
- Critical path: one SLICE-bit slice plus the carry register. There is no WIDTH-long ripple.

## Test plan
- Reset: assert rst asynchronously between clock edges -> busy, done, f, cout and zero are 0 immediately, without waiting for a clock edge.
- Add, WIDTH=16/SLICE=4: m=0, s=1001, cin=0, a=0x1234, b=0x0FCD, pulse start -> busy high for 4 cycles, then done for 1 cycle with f=0x2201, cout=0, zero=0.
- Cross-slice carry: add with a=0xFFFF, b=0x0001 -> f=0x0000, cout=1, zero=1. Then change a to 0x0000 without a start -> f, cout and zero are unchanged.
- Subtract: m=0, s=0110, cin=1, a=0x0005, b=0x0007 -> f=0xFFFE, cout=0. Repeat with a=0x0007, b=0x0005 -> f=0x0002, cout=1.
- Logic XOR with ignored start:
  - m=1, s=0110, cin=1, a=0xF0F0, b=0xFF00 -> f=0x0FF0, cout=0.
  - A second start pulsed mid-run, with other operands, is ignored: exactly one done.
  - Start asserted in the done cycle is accepted, and its done follows 4 cycles later.
- Reset mid-op and generic width:
  - rst during cycle 2 of an add -> no done, outputs 0; a fresh operation after release completes normally.
  - Instance with WIDTH=32, SLICE=8, a=0xFFFFFFFF, b=0x00000001, add -> done after 4 cycles with f=0, cout=1, zero=1.

Source files
------------

// File: rtl/alu_slice_serial.sv
// Multi-cycle M/S-function ALU: evaluates WIDTH bits one SLICE per clock, LSB first,
// with the inter-slice carry held in a register so the critical path is one slice.
module alu_slice_serial #(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             m_i,
   input  logic [3:0]       s_i,
   input  logic             cin_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] f_o,
   output logic             cout_o,
   output logic             zero_o
);

   localparam int N  = WIDTH / SLICE;
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic {IDLE, RUN} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, part_q, part_d, f_q, f_d;
   logic             m_q, m_d, carry_q, carry_d, cout_q, cout_d, zero_q, zero_d, done_q, done_d;
   logic [3:0]       s_q, s_d;
   logic [IW-1:0]    idx_q, idx_d;

   logic [SLICE-1:0] sa, sb, x, y, lres, res;
   logic [SLICE:0]   sum;
   logic             sc;

   // Every arithmetic code is X + Y + carry for bitwise X/Y; "minus 1" adds all ones.
   always_comb begin
      sa = a_q[idx_q*SLICE +: SLICE];
      sb = b_q[idx_q*SLICE +: SLICE];
      x  = sa;
      y  = '0;
      unique case (s_q)
         4'b0000: begin x = sa;        y = '0;        end
         4'b0001: begin x = sa | sb;   y = '0;        end
         4'b0010: begin x = sa | ~sb;  y = '0;        end
         4'b0011: begin x = '0;        y = '1;        end
         4'b0100: begin x = sa;        y = sa & ~sb;  end
         4'b0101: begin x = sa | sb;   y = sa & ~sb;  end
         4'b0110: begin x = sa;        y = ~sb;       end
         4'b0111: begin x = sa & ~sb;  y = '1;        end
         4'b1000: begin x = sa;        y = sa & sb;   end
         4'b1001: begin x = sa;        y = sb;        end
         4'b1010: begin x = sa | ~sb;  y = sa & sb;   end
         4'b1011: begin x = sa & sb;   y = '1;        end
         4'b1100: begin x = sa;        y = sa;        end
         4'b1101: begin x = sa | sb;   y = sa;        end
         4'b1110: begin x = sa | ~sb;  y = sa;        end
         default: begin x = sa;        y = '1;        end
      endcase
      sum = {1'b0, x} + {1'b0, y} + {{SLICE{1'b0}}, carry_q};
      unique case (s_q)
         4'b0000: lres = ~sa;
         4'b0001: lres = ~(sa | sb);
         4'b0010: lres = ~sa & sb;
         4'b0011: lres = '0;
         4'b0100: lres = ~(sa & sb);
         4'b0101: lres = ~sb;
         4'b0110: lres = sa ^ sb;
         4'b0111: lres = sa & ~sb;
         4'b1000: lres = ~sa | sb;
         4'b1001: lres = ~(sa ^ sb);
         4'b1010: lres = sb;
         4'b1011: lres = sa & sb;
         4'b1100: lres = '1;
         4'b1101: lres = sa | ~sb;
         4'b1110: lres = sa | sb;
         default: lres = sa;
      endcase
      res = m_q ? lres : sum[SLICE-1:0];
      sc  = m_q ? 1'b0 : sum[SLICE];
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      m_d     = m_q;
      s_d     = s_q;
      carry_d = carry_q;
      idx_d   = idx_q;
      part_d  = part_q;
      f_d     = f_q;
      cout_d  = cout_q;
      zero_d  = zero_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: if (start_i) begin
            a_d     = a_i;
            b_d     = b_i;
            m_d     = m_i;
            s_d     = s_i;
            carry_d = cin_i & ~m_i;
            idx_d   = '0;
            part_d  = '0;
            state_d = RUN;
         end
         default: begin
            part_d[idx_q*SLICE +: SLICE] = res;
            carry_d = sc;
            idx_d   = idx_q + 1'b1;
            if (idx_q == IW'(N - 1)) begin
               f_d     = part_d;
               cout_d  = sc;
               zero_d  = (part_d == '0);
               done_d  = 1'b1;
               idx_d   = '0;
               state_d = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         m_q     <= 1'b0;
         s_q     <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         part_q  <= '0;
         f_q     <= '0;
         cout_q  <= 1'b0;
         zero_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         m_q     <= m_d;
         s_q     <= s_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
         part_q  <= part_d;
         f_q     <= f_d;
         cout_q  <= cout_d;
         zero_q  <= zero_d;
         done_q  <= done_d;
      end
   end

   assign busy_o = (state_q == RUN);
   assign done_o = done_q;
   assign f_o    = f_q;
   assign cout_o = cout_q;
   assign zero_o = zero_q;

endmodule
